pueo_phase_lock_ctrl: RTL and testbench

Sequencing and supervision controller for the aclk-domain first-phase strobe produced by the clock-phase alignment block. It sits in the aclk domain, acquires the strobe, checks that it recurs exactly every PERIOD cycles, and declares lock after LOCK_COUNT consecutive good periods. Once locked it publishes the current phase index and a qualified phase-0 strobe to downstream aclk/memclk-crossing logic. It detects slips and timeouts and keeps a saturating error count.

---
 rtl/pueo_phase_lock_ctrl.sv | 130 +++++++++++++
 tb/tb_pueo_phase_lock_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pueo_phase_lock_ctrl.sv
// Phase-strobe acquisition, lock supervision and slip/timeout tracking.
// Publishes phase index and qualified phase-0 strobe once locked.
module pueo_phase_lock_ctrl #(
  parameter int unsigned PERIOD     = 3,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       en_i,
  input  logic       sync_i,
  input  logic       err_clr_i,
  output logic       locked_o,
  output logic [1:0] phase_o,
  output logic       phase0_o,
  output logic       slip_o,
  output logic       fault_o,
  output logic [7:0] err_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEEK   = 3'd1,
    VERIFY = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [1:0]  CNT_LAST  = 2'(PERIOD - 1);
  localparam logic [7:0]  GOOD_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam bit          ONE_SHOT  = (LOCK_COUNT == 1);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n, cnt_step;
  logic [7:0]  good, good_n;
  logic [15:0] tmo, tmo_n;
  logic [7:0]  err, err_n;
  logic        slip, slip_n;
  logic        exp_hi, hit, err_inc;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt   <= '0;
      good  <= '0;
      tmo   <= '0;
      err   <= '0;
      slip  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      good  <= good_n;
      tmo   <= tmo_n;
      err   <= err_n;
      slip  <= slip_n;
    end
  end

  always_comb begin
    exp_hi   = (cnt == 2'd0);
    hit      = (sync_i == exp_hi);
    cnt_step = (cnt == CNT_LAST) ? 2'd0 : cnt + 2'd1;
    state_n  = state;
    cnt_n    = cnt;
    good_n   = good;
    tmo_n    = tmo;
    slip_n   = 1'b0;
    err_inc  = 1'b0;
    if (!en_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      good_n  = '0;
      tmo_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = SEEK;
          cnt_n   = '0;
          good_n  = '0;
          tmo_n   = '0;
        end
        SEEK: begin
          // The strobe cycle itself is phase 0.
          if (sync_i) begin
            cnt_n   = 2'd1;
            good_n  = 8'd1;
            tmo_n   = '0;
            state_n = ONE_SHOT ? LOCKED : VERIFY;
          end else if (tmo == TMO_LAST) begin
            state_n = FAULT;
          end else begin
            tmo_n = tmo + 16'd1;
          end
        end
        VERIFY, LOCKED: begin
          if (hit) begin
            cnt_n = cnt_step;
            if (state == VERIFY && exp_hi) begin
              good_n = good + 8'd1;
              if (good == GOOD_LAST) state_n = LOCKED;
            end
          end else begin
            err_inc = 1'b1;
            slip_n  = (state == LOCKED);
            state_n = SEEK;
            cnt_n   = '0;
            good_n  = '0;
            tmo_n   = '0;
          end
        end
        FAULT: ;
        default: state_n = IDLE;
      endcase
    end
    if (err_clr_i) err_n = '0;
    else if (err_inc && err != 8'hff) err_n = err + 8'd1;
    else err_n = err;
  end

  assign locked_o  = (state == LOCKED);
  assign fault_o   = (state == FAULT);
  assign phase_o   = locked_o ? cnt : 2'd0;
  assign phase0_o  = locked_o && (cnt == 2'd0);
  assign slip_o    = slip;
  assign err_cnt_o = err;
  assign state_o   = state;

endmodule

// File: tb/tb_pueo_phase_lock_ctrl.sv
// Randomized and directed bench for pueo_phase_lock_ctrl
// against a cycle-time reference model.
module tb_pueo_phase_lock_ctrl;

  localparam int P  = 3;
  localparam int LC = 16;
  localparam int TO = 64;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       en_i = 1'b0;
  logic       sync_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       locked_o;
  logic [1:0] phase_o;
  logic       phase0_o;
  logic       slip_o;
  logic       fault_o;
  logic [7:0] err_cnt_o;
  logic [2:0] state_o;

  int n_chk = 0;
  int n_pass = 0;

  // model: states 0..4, anchor = cycle of accepted strobe
  int ms, anchor, ngood, nseek, merr, mc;
  bit mslip;

  pueo_phase_lock_ctrl #(
    .PERIOD(P),
    .LOCK_COUNT(LC),
    .TIMEOUT(TO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .en_i(en_i),
    .sync_i(sync_i),
    .err_clr_i(err_clr_i),
    .locked_o(locked_o),
    .phase_o(phase_o),
    .phase0_o(phase0_o),
    .slip_o(slip_o),
    .fault_o(fault_o),
    .err_cnt_o(err_cnt_o),
    .state_o(state_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ms = 0; anchor = 0; ngood = 0; nseek = 0;
    merr = 0; mslip = 0;
  endtask

  task automatic model_step(bit en, bit sy, bit clr);
    bit inc;
    bit e;
    inc = 0;
    mslip = 0;
    if (!en) ms = 0;
    else begin
      case (ms)
        0: begin ms = 1; nseek = 0; end
        1: begin
          if (sy) begin
            anchor = mc; ngood = 1;
            ms = (LC == 1) ? 3 : 2;
          end else begin
            nseek++;
            if (nseek == TO) ms = 4;
          end
        end
        2, 3: begin
          e = ((mc - anchor) % P) == 0;
          if (sy != e) begin
            inc = 1; mslip = (ms == 3);
            ms = 1; nseek = 0;
          end else if (e && ms == 2) begin
            ngood++;
            if (ngood == LC) ms = 3;
          end
        end
        default: ;
      endcase
    end
    if (clr) merr = 0;
    else if (inc && merr < 255) merr++;
    mc++;
  endtask

  task automatic check_all();
    int ph;
    ph = (mc - anchor) % P;
    chk("state", state_o, ms);
    chk("locked", locked_o, ms == 3);
    chk("fault", fault_o, ms == 4);
    chk("slip", slip_o, mslip);
    chk("err", err_cnt_o, merr);
    chk("phase0", phase0_o, (ms == 3) && ph == 0);
    if (ms == 3) chk("phase", phase_o, ph);
  endtask

  task automatic tick(bit en, bit sy, bit clr);
    en_i = en; sync_i = sy; err_clr_i = clr;
    @(posedge aclk);
    model_step(en, sy, clr);
    #1;
    check_all();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_locked"}, locked_o, 0);
    chk({tag, "_phase0"}, phase0_o, 0);
    chk({tag, "_phase"}, phase_o, 0);
    chk({tag, "_slip"}, slip_o, 0);
    chk({tag, "_fault"}, fault_o, 0);
    chk({tag, "_err"}, err_cnt_o, 0);
    chk({tag, "_state"}, state_o, 0);
  endtask

  // en rises at cycle 0, strobes at 5, 8, 11, ...
  task automatic clean_lock(string tag, int ncyc);
    bit sy;
    for (int i = 0; i < ncyc; i++) begin
      sy = (i >= 5) && ((i - 5) % P == 0);
      tick(1, sy, 0);
      if (i + 1 == 50) chk({tag, "_pre"}, locked_o, 0);
      if (i + 1 == 51) chk({tag, "_at51"}, locked_o, 1);
      if (i + 1 == 53) chk({tag, "_ph0_53"}, phase0_o, 1);
      if (i + 1 == 54) chk({tag, "_ph_54"}, phase_o, 1);
    end
  endtask

  initial begin
    bit sy, en, clr;
    model_reset();
    mc = 0;
    #12;
    check_zero("rst");
    aresetn = 1'b1;

    clean_lock("lock", 60);
    chk("lock_err", err_cnt_o, 0);

    tick(0, 0, 0);
    for (int i = 0; i < 70; i++) begin
      tick(1, 0, 0);
      if (i + 1 == 64) chk("tmo_pre", fault_o, 0);
      if (i + 1 == 65) begin
        chk("tmo_fault", fault_o, 1);
        chk("tmo_state", state_o, 4);
      end
    end
    tick(0, 0, 0);
    chk("tmo_exit_state", state_o, 0);
    chk("tmo_exit_fault", fault_o, 0);

    for (int i = 0; i < 70; i++) begin
      tick(1, i == 64, 0);
      if (i + 1 == 65) chk("tmo_edge_win", state_o, 2);
    end

    tick(0, 0, 1);
    for (int i = 0; i < 120; i++) begin
      sy = (i >= 5) && ((i < 62 && (i - 5) % P == 0) ||
                        (i >= 63 && (i - 63) % P == 0));
      tick(1, sy, 0);
      if (i + 1 == 63) begin
        chk("slip_pulse", slip_o, 1);
        chk("slip_locked", locked_o, 0);
        chk("slip_err", err_cnt_o, 1);
      end
      if (i + 1 == 64) chk("slip_once", slip_o, 0);
      if (i + 1 == 108) chk("relock_pre", locked_o, 0);
      if (i + 1 == 109) chk("relock", locked_o, 1);
    end

    tick(0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      sy = (i >= 5 && i <= 17 && (i - 5) % P == 0) || i == 18;
      tick(1, sy, 0);
      if (i + 1 == 19) begin
        chk("extra_state", state_o, 1);
        chk("extra_err", err_cnt_o, 1);
        chk("extra_locked", locked_o, 0);
      end
    end

    tick(0, 0, 1);
    for (int i = 0; i < 620; i++) tick(1, 1, 0);
    chk("sat_err", err_cnt_o, 255);
    chk("sat_state", state_o, 2);
    tick(1, 1, 1);
    chk("clr_prio", err_cnt_o, 0);

    tick(0, 0, 0);
    clean_lock("pre_rst", 60);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check_zero("mid_rst");
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    clean_lock("relock_rst", 60);

    for (int j = 0; j < 3000; j++) begin
      en = ($urandom_range(0, 399) != 0);
      clr = ($urandom_range(0, 199) == 0);
      sy = ((j % P) == 0) ^ ($urandom_range(0, 149) == 0);
      tick(en, sy, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
